// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder is stepped over WIDTH
// cycles, LSB first, with the inter-bit carry held in a flop.

module fulladder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic               start_q_r;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               accept_s;
    logic               fa_s;
    logic               fa_c;

    // Only a fresh rising edge of start while idle launches an addition;
    // edges seen mid-operation are dropped rather than queued.
    assign accept_s = start & ~start_q_r & (state_r == ST_IDLE);

    fulladder u_fa (
        .x  (a_sr_r[0]),
        .y  (b_sr_r[0]),
        .ci (carry_r),
        .s  (fa_s),
        .co (fa_c)
    );

    // Sequencer: operand shift registers, accumulator, carry flop and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            start_q_r <= 1'b0;
            a_sr_r    <= '0;
            b_sr_r    <= '0;
            acc_r     <= '0;
            carry_r   <= 1'b0;
            cnt_r     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q_r <= start;
            done      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        carry_r <= cin;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_ADD;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_ADD: begin
                    busy    <= 1'b1;
                    acc_r   <= {fa_s, acc_r[WIDTH-1:1]};
                    carry_r <= fa_c;
                    a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
                    // The last bit lands straight in the output; cnt never wraps.
                    if (cnt_r == CNT_LAST) begin
                        sum     <= {fa_s, acc_r[WIDTH-1:1]};
                        cout    <= fa_c;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus random
// traffic, every cycle compared against a cycle-count based reference model.

module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;
    int cyc;
    int done_pulses;
    int busy_cycles;

    // Reference model: an op accepted at edge k lands at k+W, frees at k+W+2
    logic         m_start_q;
    logic [W:0]   m_res;
    logic [W-1:0] m_sum;
    logic         m_cout;
    int           m_idle_from;
    int           m_done_edge;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ci, input logic r);
        start = st;
        a     = aa;
        b     = bb;
        cin   = ci;
        rst   = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_start_q   = 1'b0;
            m_sum       = '0;
            m_cout      = 1'b0;
            m_idle_from = cyc + 1;
            m_done_edge = -1;
        end else begin
            if (st && !m_start_q && cyc >= m_idle_from) begin
                m_res       = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
                m_done_edge = cyc + W;
                m_idle_from = cyc + W + 2;
            end
            m_start_q = st;
            if (cyc == m_done_edge) begin
                {m_cout, m_sum} = m_res;
            end
        end
        #1;
        check_eq("busy", 32'(busy), 32'(cyc < m_idle_from - 1));
        check_eq("done", 32'(done), 32'(cyc == m_done_edge));
        check_eq("result", 32'({cout, sum}), 32'({m_cout, m_sum}));
        if (done === 1'b1) done_pulses++;
        if (busy === 1'b1) busy_cycles++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        m_start_q   = 1'b0;
        m_sum       = '0;
        m_cout      = 1'b0;
        m_res       = '0;
        m_idle_from = 0;
        m_done_edge = -1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0; rst = 1'b1;

        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        check_eq("reset_sum", 32'(sum), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        idle(2);

        // 3 + 5: busy exactly W+1 cycles, one done pulse
        done_pulses = 0; busy_cycles = 0;
        cycle(1'b1, 4'd3, 4'd5, 1'b0, 1'b0);
        idle(8);
        check_eq("t1_sum", 32'({cout, sum}), 32'd8);
        check_eq("t1_busy_cycles", 32'(busy_cycles), 32'd5);
        check_eq("t1_done_pulses", 32'(done_pulses), 32'd1);

        cycle(1'b1, 4'd15, 4'd1, 1'b0, 1'b0);
        idle(6);
        check_eq("t2_sum", 32'({cout, sum}), 32'h10);
        cycle(1'b1, 4'd15, 4'd15, 1'b1, 1'b0);
        idle(6);
        check_eq("t3_sum", 32'({cout, sum}), 32'h1f);

        // start held high for 20 cycles -> a single operation
        done_pulses = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
        idle(4);
        check_eq("held_done_pulses", 32'(done_pulses), 32'd1);
        check_eq("held_sum", 32'({cout, sum}), 32'd4);

        // second edge mid-operation with new operands is dropped
        done_pulses = 0;
        cycle(1'b1, 4'd1, 4'd6, 1'b0, 1'b0);
        cycle(1'b0, 4'd7, 4'd7, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 4'd7, 1'b0, 1'b0);
        cycle(1'b0, 4'd7, 4'd7, 1'b0, 1'b0);
        idle(8);
        check_eq("drop_sum", 32'({cout, sum}), 32'd7);
        check_eq("drop_done_pulses", 32'(done_pulses), 32'd1);

        // reset two cycles into an operation aborts it
        done_pulses = 0;
        cycle(1'b1, 4'd9, 4'd9, 1'b1, 1'b0);
        cycle(1'b0, 4'd9, 4'd9, 1'b1, 1'b0);
        cycle(1'b0, 4'd9, 4'd9, 1'b1, 1'b1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_sum", 32'({cout, sum}), 32'd0);
        idle(8);
        check_eq("abort_done_pulses", 32'(done_pulses), 32'd0);
        cycle(1'b1, 4'd6, 4'd5, 1'b1, 1'b0);
        idle(6);
        check_eq("after_abort_sum", 32'({cout, sum}), 32'd12);

        // exhaustive back-to-back, operands scrambled after acceptance
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            cycle(1'b1, v[3:0], v[7:4], v[8], 1'b0);
            idle(W + 1);
        end

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
